comp_traceback: RTL and testbench

Survivor-path traceback unit for the trellis decoder. Stores one decision vector per trellis step, as written by the ACS/comparator stage, together with the winning end state and its valid flag from the final comparator tree. Once a frame closes, it walks the stored decisions backwards and emits one decoded bit per step over a valid/ready stream. It is the reader of the decision memory that the comparator stage writes.

---
 rtl/comp_tb_pkg.sv | 14 +
 rtl/comp_traceback_if.sv | 33 +++
 rtl/comp_tb_lifo.sv | 46 ++++
 rtl/comp_traceback.sv | 147 ++++++++++++++
 tb/tb_comp_traceback.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/comp_tb_pkg.sv
// Shared encodings and default geometry for the survivor-path traceback unit.
package comp_tb_pkg;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_TRACE = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  localparam int ST_WD_DEF  = 3;
  localparam int DEPTH_DEF  = 16;
  localparam int CNT_WD_DEF = $clog2(DEPTH_DEF);

endpackage

// File: rtl/comp_traceback_if.sv
// Decision-in / decoded-bit-out stream bundle between the comparator stage,
// the traceback unit and its downstream consumer.
interface comp_traceback_if
  import comp_tb_pkg::*;
#(
  parameter int st_wd  = ST_WD_DEF,
  parameter int cnt_wd = CNT_WD_DEF
);

  logic [2**st_wd-1:0] in_dec;
  logic                in_vd;
  logic                in_rdy;
  logic                in_last;
  logic [st_wd-1:0]    in_best_idx;
  logic                in_best_dv;
  logic                out_dat;
  logic [cnt_wd-1:0]   out_idx;
  logic                out_vd;
  logic                out_rdy;
  logic                out_last;
  logic                tb_ovf;

  modport master (
    output in_dec, in_vd, in_last, in_best_idx, in_best_dv, out_rdy,
    input  in_rdy, out_dat, out_idx, out_vd, out_last, tb_ovf
  );

  modport slave (
    input  in_dec, in_vd, in_last, in_best_idx, in_best_dv, out_rdy,
    output in_rdy, out_dat, out_idx, out_vd, out_last, tb_ovf
  );

endinterface

// File: rtl/comp_tb_lifo.sv
// Single-bit stack used to turn the backwards traceback into forward bit order.
module comp_tb_lifo #(
  parameter int depth  = 16,
  parameter int lvl_wd = $clog2(depth) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_dat,
  output logic              o_top,
  output logic [lvl_wd-1:0] o_level
);

  localparam int idx_wd = lvl_wd - 1;

  logic              r_stack [depth];
  logic [lvl_wd-1:0] r_level;
  logic [idx_wd-1:0] w_wr_idx;
  logic [idx_wd-1:0] w_rd_idx;
  logic              w_full;
  logic              w_empty;

  assign w_full   = (r_level == lvl_wd'(depth));
  assign w_empty  = (r_level == '0);
  assign w_wr_idx = r_level[idx_wd-1:0];
  assign w_rd_idx = w_wr_idx - 1'b1;

  always_ff @(posedge clk) begin
    if (i_push && !w_full) r_stack[w_wr_idx] <= i_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else if (i_push && !w_full) begin
      r_level <= r_level + 1'b1;
    end else if (i_pop && !w_empty) begin
      r_level <= r_level - 1'b1;
    end
  end

  assign o_top   = r_stack[w_rd_idx];
  assign o_level = r_level;

endmodule

// File: rtl/comp_traceback.sv
// Survivor-path traceback: stores per-step decisions, walks them back from the
// winning end state and streams decoded bits. COMP_TB_REVERSE_EN emits forward order.
module comp_traceback
  import comp_tb_pkg::*;
#(
  parameter int st_wd  = ST_WD_DEF,
  parameter int depth  = DEPTH_DEF,
  parameter int cnt_wd = CNT_WD_DEF
) (
  input logic             clk,
  input logic             rst_n,
  comp_traceback_if.slave bus
);

  localparam int                n_st      = 2 ** st_wd;
  localparam logic [cnt_wd-1:0] last_slot = cnt_wd'(depth - 1);

  state_t            r_state;
  logic [n_st-1:0]   r_mem [depth];
  logic [cnt_wd-1:0] r_wr_cnt;
  logic [cnt_wd-1:0] r_rd_cnt;
  logic [st_wd-1:0]  r_cur_st;
  logic              r_ovf;

  logic              w_accept;
  logic              w_close;
  logic              w_force;
  logic              w_bit;
  logic              w_dec;
  logic [st_wd-1:0]  w_next_st;

  assign w_accept  = bus.in_vd && (r_state == S_FILL);
  assign w_force   = w_accept && !bus.in_last && (r_wr_cnt == last_slot);
  assign w_close   = w_accept && (bus.in_last || (r_wr_cnt == last_slot));

  // Decoded bit is the state MSB; the stored decision refills the LSB end.
  assign w_bit     = r_cur_st[st_wd-1];
  assign w_dec     = r_mem[r_rd_cnt][r_cur_st];
  assign w_next_st = {r_cur_st[st_wd-2:0], w_dec};

  // NOTE: storage arrays carry no reset; every slot read is written first in the frame.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_cnt] <= bus.in_dec;
  end

`ifdef COMP_TB_REVERSE_EN
  logic [cnt_wd-1:0] r_len;
  logic [cnt_wd-1:0] r_emit_idx;
  logic              w_push;
  logic              w_pop;
  logic              w_top;
  logic [cnt_wd:0]   w_level;

  assign w_push = (r_state == S_TRACE);
  assign w_pop  = bus.out_vd && bus.out_rdy;

  comp_tb_lifo #(
    .depth  (depth),
    .lvl_wd (cnt_wd + 1)
  ) u_lifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (w_bit),
    .o_top   (w_top),
    .o_level (w_level)
  );

  assign bus.out_vd   = (r_state == S_EMIT) && (w_level != '0);
  assign bus.out_dat  = bus.out_vd && w_top;
  assign bus.out_idx  = bus.out_vd ? r_emit_idx : '0;
  assign bus.out_last = bus.out_vd && (r_emit_idx == r_len);
`else
  assign bus.out_vd   = (r_state == S_TRACE);
  assign bus.out_dat  = bus.out_vd && w_bit;
  assign bus.out_idx  = bus.out_vd ? r_rd_cnt : '0;
  assign bus.out_last = bus.out_vd && (r_rd_cnt == '0);
`endif

  assign bus.in_rdy = (r_state == S_FILL);
  assign bus.tb_ovf = r_ovf;

  // NOTE: all state below updates with <= so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FILL;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_cur_st   <= '0;
      r_ovf      <= 1'b0;
`ifdef COMP_TB_REVERSE_EN
      r_len      <= '0;
      r_emit_idx <= '0;
`endif
    end else begin
      r_ovf <= w_force;
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_close) begin
              r_rd_cnt <= r_wr_cnt;
              r_cur_st <= bus.in_best_dv ? bus.in_best_idx : '0;
              r_state  <= S_TRACE;
`ifdef COMP_TB_REVERSE_EN
              r_len    <= r_wr_cnt;
`endif
            end
          end
        end
        S_TRACE: begin
`ifdef COMP_TB_REVERSE_EN
          r_cur_st <= w_next_st;
          r_rd_cnt <= r_rd_cnt - 1'b1;
          if (r_rd_cnt == '0) begin
            r_state    <= S_EMIT;
            r_emit_idx <= '0;
          end
`else
          if (bus.out_rdy) begin
            r_cur_st <= w_next_st;
            r_rd_cnt <= r_rd_cnt - 1'b1;
            if (r_rd_cnt == '0) begin
              r_wr_cnt <= '0;
              r_state  <= S_FILL;
            end
          end
`endif
        end
`ifdef COMP_TB_REVERSE_EN
        S_EMIT: begin
          if (bus.out_vd && bus.out_rdy) begin
            r_emit_idx <= r_emit_idx + 1'b1;
            if (r_emit_idx == r_len) begin
              r_wr_cnt <= '0;
              r_state  <= S_FILL;
            end
          end
        end
`endif
        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_traceback.sv
// Scoreboard bench for comp_traceback: directed frames push expected bits, a
// monitor pops and compares on every out_vd/out_rdy transfer.
module tb_comp_traceback;
  import comp_tb_pkg::*;

  typedef struct packed {
    logic       dat;
    logic [3:0] idx;
    logic       last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  comp_traceback_if #(.st_wd(3), .cnt_wd(4)) u_if ();

  comp_traceback #(.st_wd(3), .depth(16), .cnt_wd(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_xfer   = 0;
  int   n_frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares each transfer against the scoreboard and checks hold under stall.
  logic p_stall = 1'b0;
  exp_t p_out;
  always @(negedge clk) begin
    exp_t e;
    exp_t cur;
    cur = '{dat: u_if.out_dat, idx: u_if.out_idx, last: u_if.out_last};
    if (!rst_n) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        check("hold_vd", 32'(u_if.out_vd), 32'd1);
        check("hold_out", 32'(cur), 32'(p_out));
      end
      if (u_if.out_vd && u_if.out_rdy) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out: got idx %0d dat %0d, required no transfer", cur.idx, cur.dat);
        end else begin
          e = sb_q.pop_front();
          check("out_dat", 32'(cur.dat), 32'(e.dat));
          check("out_idx", 32'(cur.idx), 32'(e.idx));
          check("out_last", 32'(cur.last), 32'(e.last));
        end
        n_xfer++;
        if (cur.last) n_frames++;
      end
      p_stall = u_if.out_vd && !u_if.out_rdy;
      p_out   = cur;
    end
  end

  // bits[i] is the hand-traced decoded bit of step i; queued in emission order.
  task automatic push_frame(input logic [15:0] bits, input int len);
`ifdef COMP_TB_REVERSE_EN
    for (int i = 0; i <= len; i++)
      sb_q.push_back('{dat: bits[i], idx: 4'(i), last: (i == len)});
`else
    for (int i = len; i >= 0; i--)
      sb_q.push_back('{dat: bits[i], idx: 4'(i), last: (i == 0)});
`endif
  endtask

  task automatic step(input logic [7:0] dec, input logic last,
                      input logic [2:0] bidx, input logic bdv);
    check("in_rdy_fill", 32'(u_if.in_rdy), 32'd1);
    u_if.in_vd       = 1'b1;
    u_if.in_dec      = dec;
    u_if.in_last     = last;
    u_if.in_best_idx = bidx;
    u_if.in_best_dv  = bdv;
    @(posedge clk);
    #1;
    u_if.in_vd      = 1'b0;
    u_if.in_last    = 1'b0;
    u_if.in_best_dv = 1'b0;
  endtask

  task automatic check_first_out(input int len);
`ifdef COMP_TB_REVERSE_EN
    for (int i = 0; i <= len; i++) begin
      check("no_out_during_trace", 32'(u_if.out_vd), 32'd0);
      @(posedge clk);
      #1;
    end
`endif
    check("first_out_vd", 32'(u_if.out_vd), 32'd1);
  endtask

  task automatic wait_frame(input int budget);
    int start;
    int k;
    start = n_frames;
    k = 0;
    while (n_frames == start && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("frame_done", 32'(n_frames != start), 32'd1);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("in_rdy_after", 32'(u_if.in_rdy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x0;
    u_if.in_dec      = '0;
    u_if.in_vd       = 1'b0;
    u_if.in_last     = 1'b0;
    u_if.in_best_idx = '0;
    u_if.in_best_dv  = 1'b0;
    u_if.out_rdy     = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_rdy", 32'(u_if.in_rdy), 32'd1);
    check("rst_out_vd", 32'(u_if.out_vd), 32'd0);
    check("rst_outs", 32'({u_if.out_dat, u_if.out_idx, u_if.out_last}), 32'd0);
    check("rst_ovf", 32'(u_if.tb_ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame 1: zero decisions from state 101 -> bits idx3..0 = 1,0,1,0
    push_frame(16'h000A, 3);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 3'b000, 1'b0);
    step(8'h00, 1'b1, 3'b101, 1'b1);
    check("ovf_normal_close", 32'(u_if.tb_ovf), 32'd0);
    check("in_rdy_trace", 32'(u_if.in_rdy), 32'd0);
    check_first_out(3);
    wait_frame(40);

    // Abort mid-trace with the output stalled; nothing is queued for it.
    u_if.out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 3'b000, 1'b0);
    step(8'h00, 1'b1, 3'b101, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_rdy", 32'(u_if.in_rdy), 32'd1);
    check("midrst_out_vd", 32'(u_if.out_vd), 32'd0);
    check("midrst_outs", 32'({u_if.out_dat, u_if.out_idx, u_if.out_last}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_in_rdy", 32'(u_if.in_rdy), 32'd1);
    check("postrst_out_vd", 32'(u_if.out_vd), 32'd0);
    u_if.out_rdy = 1'b1;

    // Backpressure: same frame, out_rdy low 3 cycles after the first bit.
    x0 = n_xfer;
    push_frame(16'h000A, 3);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 3'b000, 1'b0);
    step(8'h00, 1'b1, 3'b101, 1'b1);
    for (int k = 0; k < 30 && !u_if.out_vd; k++) begin
      @(posedge clk);
      #1;
    end
    check("bp_first_vd", 32'(u_if.out_vd), 32'd1);
    @(posedge clk);
    #1;
    u_if.out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_xfer_stalled", 32'(n_xfer - x0), 32'd1);
    u_if.out_rdy = 1'b1;
    wait_frame(40);
    check("bp_xfer_count", 32'(n_xfer - x0), 32'd4);

    // Invalid best (idx 111 ignored), all-ones decisions: start at 0 -> 0,0,0
    push_frame(16'h0000, 2);
    step(8'hFF, 1'b0, 3'b111, 1'b1);
    step(8'hFF, 1'b0, 3'b111, 1'b1);
    step(8'hFF, 1'b1, 3'b111, 1'b0);
    wait_frame(40);

    // Mixed decisions from 110: idx4..0 = 1,1,0,0,1
    push_frame(16'h0019, 4);
    step(8'hA5, 1'b0, 3'b000, 1'b0);
    step(8'h3C, 1'b0, 3'b000, 1'b0);
    step(8'h0F, 1'b0, 3'b000, 1'b0);
    step(8'hF0, 1'b0, 3'b000, 1'b0);
    step(8'h96, 1'b1, 3'b110, 1'b1);
    check_first_out(4);
    wait_frame(40);

    // Overflow: 16 steps without in_last, all-ones from state 0
    x0 = n_xfer;
    push_frame(16'h1FFF, 15);
    for (int i = 0; i < 16; i++) step(8'hFF, 1'b0, 3'b000, 1'b1);
    check("ovf_pulse", 32'(u_if.tb_ovf), 32'd1);
    check("ovf_in_rdy", 32'(u_if.in_rdy), 32'd0);
    @(posedge clk);
    #1;
    check("ovf_pulse_end", 32'(u_if.tb_ovf), 32'd0);
    check("ovf_in_rdy_trace", 32'(u_if.in_rdy), 32'd0);
    wait_frame(100);
    check("ovf_xfer_count", 32'(n_xfer - x0), 32'd16);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
